// File: rtl/e_mdu_seq_pkg.sv
// Op codes, FSM states and op-class helpers shared by the multiply/divide unit.
package e_mdu_seq_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;
    typedef enum logic [1:0] {ACC_SET, ACC_ADD, ACC_SUB} acc_t;

    function automatic logic is_mult(input logic [3:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_long_op(input logic [3:0] op);
        return is_mult(op) || is_div(op);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    endfunction

endpackage

// File: rtl/e_mdu_seq_if.sv
// EX-stage to MDU request/response bundle; the pipeline is the master.
interface e_mdu_seq_if #(parameter int WIDTH = 32);
    logic             req;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] rdata;
    logic             start;
    logic             busy;

    modport master (output req, op, a, b, input rdata, start, busy);
    modport slave  (input req, op, a, b, output rdata, start, busy);
endinterface

// File: rtl/mdu_div_serial.sv
// Bit-serial restoring divider on magnitudes: one quotient bit per iterate edge, done after WIDTH.
// No backpressure; the caller owns sequencing via load/iterate.
module mdu_div_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             iterate,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_sh, diff;

    // Shift next dividend bit into the partial remainder; keep the subtraction only if no borrow.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (iterate && !done) begin
            rem_q <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], ~diff[WIDTH]};
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = (cnt_q == CW'(WIDTH));
endmodule

// File: rtl/e_mdu_seq.sv
// EX-stage multiply/divide unit owning HI/LO: mult commits MULT_LAT edges after issue, div WIDTH+1.
// No backpressure input; upstream stalls on busy|start and ops arriving while busy are ignored.
module e_mdu_seq
    import e_mdu_seq_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5
) (
    input  logic        clk,
    input  logic        reset,
    e_mdu_seq_if.slave  bus
);
    localparam int CW = $clog2(MULT_LAT + 1);

    state_t             state_q, state_d;
    acc_t               acc_q;
    logic [WIDTH-1:0]   hi, lo;
    logic [2*WIDTH-1:0] prod_q, prod_d, mac;
    logic [CW-1:0]      mcnt_q;

    logic [WIDTH-1:0]   div_a_q, q_raw, r_raw, q_fix, r_fix, a_mag, b_mag;
    logic               div_bz_q, div_ovf_q, q_neg_q, r_neg_q, div_done;
    logic               op_sgn, a_neg, b_neg;
    logic               issue_mul, issue_div, mul_commit, div_iter, div_commit, wr_ok;

    assign op_sgn = is_signed_op(bus.op);
    assign a_neg  = op_sgn & bus.a[WIDTH-1];
    assign b_neg  = op_sgn & bus.b[WIDTH-1];
    assign a_mag  = a_neg ? -bus.a : bus.a;
    assign b_mag  = b_neg ? -bus.b : bus.b;
    assign prod_d = op_sgn ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b}
                           : {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
    assign wr_ok  = (state_q == ST_IDLE) && !bus.req;

    always_comb begin
        state_d    = state_q;
        issue_mul  = 1'b0;
        issue_div  = 1'b0;
        mul_commit = 1'b0;
        div_iter   = 1'b0;
        div_commit = 1'b0;
        case (state_q)
            ST_IDLE: if (!bus.req) begin
                if (is_mult(bus.op)) begin
                    issue_mul = 1'b1;
                    state_d   = ST_MUL;
                end else if (is_div(bus.op)) begin
                    issue_div = 1'b1;
                    state_d   = ST_DIV;
                end
            end
            ST_MUL: if (mcnt_q == '0) begin
                mul_commit = 1'b1;
                state_d    = ST_IDLE;
            end else begin
                mul_commit = 1'b0;
            end
            ST_DIV: if (div_done) begin
                div_commit = 1'b1;
                state_d    = ST_IDLE;
            end else begin
                div_iter = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    mdu_div_serial #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (issue_div),
        .iterate   (div_iter),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (q_raw),
        .remainder (r_raw),
        .done      (div_done)
    );

    assign q_fix = q_neg_q ? -q_raw : q_raw;
    assign r_fix = r_neg_q ? -r_raw : r_raw;

    always_comb begin
        mac = prod_q;
        case (acc_q)
            ACC_ADD: mac = {hi, lo} + prod_q;
            ACC_SUB: mac = {hi, lo} - prod_q;
            default: mac = prod_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= ACC_SET;
            hi        <= '0;
            lo        <= '0;
            prod_q    <= '0;
            mcnt_q    <= '0;
            div_a_q   <= '0;
            div_bz_q  <= 1'b0;
            div_ovf_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_ok && bus.op == OP_MTHI) hi <= bus.a;
            if (wr_ok && bus.op == OP_MTLO) lo <= bus.a;
            if (issue_mul) begin
                prod_q <= prod_d;
                mcnt_q <= CW'(MULT_LAT - 1);
                acc_q  <= (bus.op inside {OP_MADD, OP_MADDU}) ? ACC_ADD :
                          (bus.op inside {OP_MSUB, OP_MSUBU}) ? ACC_SUB : ACC_SET;
            end else if (state_q == ST_MUL && !mul_commit) begin
                mcnt_q <= mcnt_q - 1'b1;
            end
            if (mul_commit) {hi, lo} <= mac;
            if (issue_div) begin
                div_a_q   <= bus.a;
                div_bz_q  <= (bus.b == '0);
                div_ovf_q <= (bus.op == OP_DIV) && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.b);
                q_neg_q   <= a_neg ^ b_neg;
                r_neg_q   <= a_neg;
            end
            // Divide-by-zero and MIN/-1 override the datapath result at commit.
            if (div_commit) begin
                if (div_bz_q) begin
                    lo <= '1;
                    hi <= div_a_q;
                end else if (div_ovf_q) begin
                    lo <= {1'b1, {(WIDTH-1){1'b0}}};
                    hi <= '0;
                end else begin
                    lo <= q_fix;
                    hi <= r_fix;
                end
            end
        end
    end

    assign bus.rdata = (bus.op == OP_MFHI) ? hi : (bus.op == OP_MFLO) ? lo : '0;
    assign bus.start = is_long_op(bus.op);
    assign bus.busy  = (state_q != ST_IDLE);
endmodule
